// File: rtl/sb_pkg.sv
// Shared encodings for the sideband receive message parser: FSM states,
// LTSM reset code, clock-pattern word, message constants and header field positions.
package sb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PATTERN = 3'd1,
    ST_DECODE  = 3'd2,
    ST_RDI     = 3'd3,
    ST_HEADER  = 3'd4,
    ST_DATA    = 3'd5,
    ST_ADAPTER = 3'd6
  } sb_state_e;

  localparam logic [2:0]  LTSM_RESET   = 3'd0;
  localparam logic [63:0] PATTERN_WORD = {32{2'b10}};

  localparam logic [4:0]  OPC_MEM_DATA = 5'b11011;
  localparam logic [3:0]  MSGCODE_RDI  = 4'd0;
  localparam logic [3:0]  MSGCODE2_RSP = 4'd10;

  localparam int DP_BIT       = 63;
  localparam int DSTID_MSB    = 58;
  localparam int DSTID_LSB    = 56;
  localparam int MSGCODE_MSB  = 21;
  localparam int MSGCODE_LSB  = 18;
  localparam int MSGCODE2_MSB = 17;
  localparam int MSGCODE2_LSB = 14;
  localparam int OPCODE_MSB   = 4;
  localparam int OPCODE_LSB   = 0;

  // Control parity covers everything below the data-parity bit; a valid header gives 0.
  function automatic logic ctrl_parity(input logic [63:0] word);
    return ^word[62:0];
  endfunction

endpackage

// File: rtl/sb_pattern_det.sv
// Clock-pattern recogniser with the consecutive-repetition counter used while
// the parser is in its IDLE/PATTERN phase.
module sb_pattern_det
  import sb_pkg::*;
#(
  parameter int PATTERN_REPS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] word,
  input  logic        strobe,
  input  logic        active,
  output logic        is_pat,
  output logic        reps_done
);

  localparam logic [3:0] REPS = 4'(PATTERN_REPS);

  logic [3:0] rep_cnt;
  logic [3:0] cnt_inc;

  assign is_pat    = (word == PATTERN_WORD);
  assign cnt_inc   = rep_cnt + 4'd1;
  assign reps_done = active && strobe && is_pat && (cnt_inc == REPS);

  // Counter only lives during the pattern phase; it is zero whenever decoding runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!active || reps_done) begin
      rep_cnt <= '0;
    end else if (strobe) begin
      rep_cnt <= is_pat ? cnt_inc : '0;
    end
  end

endmodule

// File: rtl/sb_rx_msg_parser.sv
// Sideband receive parser: waits for the clock pattern, then decodes headers and
// sequences RDI / header / payload completion with timeout and parity-error tracking.
module sb_rx_msg_parser
  import sb_pkg::*;
#(
  parameter int PATTERN_REPS = 2,
  parameter int DATA_WORDS   = 1,
  parameter int TIMEOUT_CYC  = 255,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_de_ser_done,
  input  logic [63:0]          i_deser_data,
  input  logic [2:0]           i_state,
  input  logic                 i_header_valid,
  input  logic                 i_rdi_valid,
  input  logic                 i_data_valid,
  input  logic                 i_err_clr,
  output logic                 o_rx_sb_start_pattern,
  output logic                 o_rx_sb_pattern_samp_done,
  output logic                 o_header_enable,
  output logic                 o_rdi_enable,
  output logic                 o_data_enable,
  output logic                 o_adapter_enable,
  output logic                 o_msg_valid,
  output logic                 o_rx_rsp_delivered,
  output logic                 o_parity_error,
  output logic                 o_timeout,
  output logic [2:0]           o_data_idx,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]           LAST_IDX = 3'(DATA_WORDS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  sb_state_e   state;
  logic [15:0] tmo_cnt;
  logic [2:0]  widx;
  logic        data_wait;
  logic        par_q;
  logic        dp_q;
  logic [4:0]  opcode_q;

  logic       is_pat;
  logic       reps_done;
  logic       pat_active;
  logic       ltsm_reset;
  logic       tmo_last;
  logic       dec_par_err;
  logic       data_par_nxt;
  logic       data_par_err;
  logic       par_err_evt;
  logic [3:0] msg_code;
  logic [3:0] msg_code2;

  assign pat_active   = (state == ST_IDLE) || (state == ST_PATTERN);
  assign ltsm_reset   = (i_state == LTSM_RESET);
  assign tmo_last     = (tmo_cnt == TMO_LAST);
  assign msg_code     = i_deser_data[MSGCODE_MSB:MSGCODE_LSB];
  assign msg_code2    = i_deser_data[MSGCODE2_MSB:MSGCODE2_LSB];
  assign dec_par_err  = i_de_ser_done && !is_pat && !i_deser_data[DSTID_LSB] &&
                        ctrl_parity(i_deser_data);
  assign data_par_nxt = par_q ^ (^i_deser_data);
  assign data_par_err = i_de_ser_done && !data_wait && !tmo_last &&
                        (widx == LAST_IDX) && data_par_nxt;
  assign par_err_evt  = !ltsm_reset &&
                        (((state == ST_DECODE) && dec_par_err) ||
                         ((state == ST_DATA) && data_par_err));

  sb_pattern_det #(
    .PATTERN_REPS(PATTERN_REPS)
  ) u_pattern_det (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .word     (i_deser_data),
    .strobe   (i_de_ser_done),
    .active   (pat_active),
    .is_pat   (is_pat),
    .reps_done(reps_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                     <= ST_IDLE;
      tmo_cnt                   <= '0;
      widx                      <= '0;
      data_wait                 <= 1'b0;
      par_q                     <= 1'b0;
      dp_q                      <= 1'b0;
      opcode_q                  <= '0;
      o_rx_sb_start_pattern     <= 1'b0;
      o_rx_sb_pattern_samp_done <= 1'b0;
      o_header_enable           <= 1'b0;
      o_rdi_enable              <= 1'b0;
      o_data_enable             <= 1'b0;
      o_adapter_enable          <= 1'b0;
      o_msg_valid               <= 1'b0;
      o_rx_rsp_delivered        <= 1'b0;
      o_parity_error            <= 1'b0;
      o_timeout                 <= 1'b0;
      o_data_idx                <= '0;
    end else begin
      o_rx_sb_start_pattern     <= 1'b0;
      o_rx_sb_pattern_samp_done <= 1'b0;
      o_header_enable           <= 1'b0;
      o_rdi_enable              <= 1'b0;
      o_data_enable             <= 1'b0;
      o_adapter_enable          <= 1'b0;
      o_msg_valid               <= 1'b0;
      o_rx_rsp_delivered        <= 1'b0;
      o_parity_error            <= 1'b0;
      o_timeout                 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_de_ser_done && is_pat) begin
            o_rx_sb_start_pattern <= ltsm_reset;
            if (reps_done) begin
              state                     <= ST_DECODE;
              o_rx_sb_pattern_samp_done <= 1'b1;
            end else begin
              state <= ST_PATTERN;
            end
          end
        end
        ST_PATTERN: begin
          if (reps_done) begin
            state                     <= ST_DECODE;
            o_rx_sb_pattern_samp_done <= 1'b1;
          end
        end
        default: begin
          // LTSM falling back to RESET abandons whatever message is in flight.
          if (ltsm_reset) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            widx      <= '0;
            data_wait <= 1'b0;
            par_q     <= 1'b0;
          end else begin
            case (state)
              ST_DECODE: begin
                if (i_de_ser_done && !is_pat) begin
                  if (i_deser_data[DSTID_LSB]) begin
                    state            <= ST_ADAPTER;
                    o_adapter_enable <= 1'b1;
                  end else if (dec_par_err) begin
                    o_parity_error <= 1'b1;
                  end else if (msg_code == MSGCODE_RDI) begin
                    state        <= ST_RDI;
                    o_rdi_enable <= 1'b1;
                    tmo_cnt      <= '0;
                  end else begin
                    state              <= ST_HEADER;
                    o_header_enable    <= 1'b1;
                    o_rx_rsp_delivered <= (msg_code2 == MSGCODE2_RSP);
                    dp_q               <= i_deser_data[DP_BIT];
                    opcode_q           <= i_deser_data[OPCODE_MSB:OPCODE_LSB];
                    tmo_cnt            <= '0;
                  end
                end
              end
              ST_ADAPTER: begin
                state <= ST_DECODE;
              end
              ST_RDI: begin
                if (i_rdi_valid) begin
                  state       <= ST_DECODE;
                  o_msg_valid <= 1'b1;
                end else if (tmo_last) begin
                  state     <= ST_DECODE;
                  o_timeout <= 1'b1;
                end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
                end
              end
              ST_HEADER: begin
                if (i_header_valid) begin
                  if (opcode_q == OPC_MEM_DATA) begin
                    state     <= ST_DATA;
                    widx      <= '0;
                    data_wait <= 1'b0;
                    par_q     <= dp_q;
                    tmo_cnt   <= '0;
                  end else begin
                    state       <= ST_DECODE;
                    o_msg_valid <= 1'b1;
                  end
                end else if (tmo_last) begin
                  state     <= ST_DECODE;
                  o_timeout <= 1'b1;
                end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
                end
              end
              ST_DATA: begin
                if (data_wait && i_data_valid) begin
                  state       <= ST_DECODE;
                  data_wait   <= 1'b0;
                  o_msg_valid <= 1'b1;
                end else if (tmo_last) begin
                  state     <= ST_DECODE;
                  data_wait <= 1'b0;
                  o_timeout <= 1'b1;
                end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
                  if (!data_wait && i_de_ser_done) begin
                    par_q <= data_par_nxt;
                    if (data_par_err) begin
                      state          <= ST_DECODE;
                      o_parity_error <= 1'b1;
                    end else begin
                      o_data_enable <= 1'b1;
                      o_data_idx    <= widx;
                      if (widx == LAST_IDX) begin
                        data_wait <= 1'b1;
                      end else begin
                        widx <= widx + 3'd1;
                      end
                    end
                  end
                end
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (i_err_clr) begin
      o_err_cnt <= '0;
    end else if (par_err_evt && (o_err_cnt != ERR_MAX)) begin
      o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sb_rx_msg_parser.sv
// Randomised self-checking bench for sb_rx_msg_parser with a message-level reference
// model (expected pulses derived from the header/payload rules per transaction).
module tb_sb_rx_msg_parser;

  localparam int PATTERN_REPS = 2;
  localparam int DATA_WORDS   = 2;
  localparam int TIMEOUT_CYC  = 255;
  localparam int ERR_CNT_W    = 8;
  localparam int ERR_MAX      = (1 << ERR_CNT_W) - 1;

  localparam logic [63:0] PAT = {32{2'b10}};

  localparam logic [9:0] P_START = 10'b10_0000_0000;
  localparam logic [9:0] P_SAMP  = 10'b01_0000_0000;
  localparam logic [9:0] P_HDR   = 10'b00_1000_0000;
  localparam logic [9:0] P_RDI   = 10'b00_0100_0000;
  localparam logic [9:0] P_DATA  = 10'b00_0010_0000;
  localparam logic [9:0] P_ADP   = 10'b00_0001_0000;
  localparam logic [9:0] P_MSG   = 10'b00_0000_1000;
  localparam logic [9:0] P_RSP   = 10'b00_0000_0100;
  localparam logic [9:0] P_PERR  = 10'b00_0000_0010;
  localparam logic [9:0] P_TMO   = 10'b00_0000_0001;

  logic                 clk;
  logic                 rst_n;
  logic                 de_ser_done;
  logic [63:0]          deser_data;
  logic [2:0]           state_in;
  logic                 header_valid;
  logic                 rdi_valid;
  logic                 data_valid;
  logic                 err_clr;
  logic                 start_pattern;
  logic                 samp_done;
  logic                 header_enable;
  logic                 rdi_enable;
  logic                 data_enable;
  logic                 adapter_enable;
  logic                 msg_valid;
  logic                 rsp_delivered;
  logic                 parity_error;
  logic                 timeout;
  logic [2:0]           data_idx;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [9:0]           pulses;

  int n_checks;
  int n_errors;
  int err_model;

  assign pulses = {start_pattern, samp_done, header_enable, rdi_enable, data_enable,
                   adapter_enable, msg_valid, rsp_delivered, parity_error, timeout};

  sb_rx_msg_parser #(
    .PATTERN_REPS(PATTERN_REPS),
    .DATA_WORDS  (DATA_WORDS),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ERR_CNT_W   (ERR_CNT_W)
  ) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_de_ser_done            (de_ser_done),
    .i_deser_data             (deser_data),
    .i_state                  (state_in),
    .i_header_valid           (header_valid),
    .i_rdi_valid              (rdi_valid),
    .i_data_valid             (data_valid),
    .i_err_clr                (err_clr),
    .o_rx_sb_start_pattern    (start_pattern),
    .o_rx_sb_pattern_samp_done(samp_done),
    .o_header_enable          (header_enable),
    .o_rdi_enable             (rdi_enable),
    .o_data_enable            (data_enable),
    .o_adapter_enable         (adapter_enable),
    .o_msg_valid              (msg_valid),
    .o_rx_rsp_delivered       (rsp_delivered),
    .o_parity_error           (parity_error),
    .o_timeout                (timeout),
    .o_data_idx               (data_idx),
    .o_err_cnt                (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] w);
    deser_data  = w;
    de_ser_done = 1'b1;
    tick();
    de_ser_done = 1'b0;
  endtask

  task automatic bump_err();
    if (err_model < ERR_MAX) err_model++;
  endtask

  function automatic logic odd_ones(input logic [63:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  // Header with even control parity; bit 30 carries no field and absorbs the fix-up.
  function automatic logic [63:0] make_hdr(input logic [3:0] mc, input logic [3:0] mc2,
                                           input logic [4:0] opc, input logic dp);
    logic [63:0] w;
    w        = {$urandom, $urandom};
    w[63]    = dp;
    w[56]    = 1'b0;
    w[21:18] = mc;
    w[17:14] = mc2;
    w[4:0]   = opc;
    if (odd_ones({1'b0, w[62:0]})) w[30] = ~w[30];
    return w;
  endfunction

  // Drives one complete message from DECODE and checks every response it should produce.
  task automatic run_msg(input logic [63:0] w, input bit good_data);
    logic [9:0]  exp;
    logic [63:0] d;
    logic        par;
    send_word(w);
    if (w == PAT) begin
      check_eq("pat_in_decode", 64'(pulses), 64'(0));
      return;
    end
    if (w[56]) begin
      check_eq("adapter_en", 64'(pulses), 64'(P_ADP));
      tick();
      check_eq("adapter_quiet", 64'(pulses), 64'(0));
      return;
    end
    if (odd_ones({1'b0, w[62:0]})) begin
      bump_err();
      check_eq("hdr_perr", 64'(pulses), 64'(P_PERR));
      check_eq("hdr_errcnt", 64'(err_cnt), 64'(err_model));
      return;
    end
    if (w[21:18] == 4'd0) begin
      check_eq("rdi_en", 64'(pulses), 64'(P_RDI));
      repeat ($urandom_range(0, 4)) tick();
      rdi_valid = 1'b1;
      tick();
      rdi_valid = 1'b0;
      check_eq("rdi_msg", 64'(pulses), 64'(P_MSG));
      check_eq("rdi_errcnt", 64'(err_cnt), 64'(err_model));
      return;
    end
    exp = P_HDR | ((w[17:14] == 4'd10) ? P_RSP : 10'd0);
    check_eq("hdr_en", 64'(pulses), 64'(exp));
    repeat ($urandom_range(0, 4)) tick();
    header_valid = 1'b1;
    tick();
    header_valid = 1'b0;
    if (w[4:0] != 5'b11011) begin
      check_eq("hdr_msg", 64'(pulses), 64'(P_MSG));
      return;
    end
    check_eq("hdr_to_data", 64'(pulses), 64'(0));
    par = w[63];
    for (int i = 0; i < DATA_WORDS; i++) begin
      d = {$urandom, $urandom};
      if (i == DATA_WORDS - 1 && ((par ^ odd_ones(d)) != !good_data)) d[7] = ~d[7];
      repeat ($urandom_range(0, 2)) tick();
      send_word(d);
      par = par ^ odd_ones(d);
      if (i < DATA_WORDS - 1 || !par) begin
        check_eq("data_en", 64'(pulses), 64'(P_DATA));
        check_eq("data_idx", 64'(data_idx), 64'(i));
      end else begin
        bump_err();
        check_eq("data_perr", 64'(pulses), 64'(P_PERR));
        check_eq("data_errcnt", 64'(err_cnt), 64'(err_model));
      end
    end
    if (!par) begin
      repeat ($urandom_range(0, 4)) tick();
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      check_eq("data_msg", 64'(pulses), 64'(P_MSG));
    end
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] bad;
    int          n;
    n_checks     = 0;
    n_errors     = 0;
    err_model    = 0;
    rst_n        = 1'b0;
    de_ser_done  = 1'b0;
    deser_data   = '0;
    state_in     = 3'd0;
    header_valid = 1'b0;
    rdi_valid    = 1'b0;
    data_valid   = 1'b0;
    err_clr      = 1'b0;

    repeat (3) tick();
    check_eq("reset_pulses", 64'(pulses), 64'(0));
    check_eq("reset_idx", 64'(data_idx), 64'(0));
    check_eq("reset_errcnt", 64'(err_cnt), 64'(0));
    rst_n = 1'b1;
    tick();

    // Pattern lock-in with LTSM in RESET, then move the LTSM on.
    w = PAT;
    w[0] = 1'b1;
    send_word(w);
    check_eq("near_pattern", 64'(pulses), 64'(0));
    send_word(PAT);
    check_eq("start_pattern", 64'(pulses), 64'(P_START));
    send_word(PAT);
    check_eq("samp_done", 64'(pulses), 64'(P_SAMP));
    state_in = 3'd3;

    run_msg(PAT, 1'b1);
    run_msg(make_hdr(4'd0, 4'd0, 5'd0, 1'b0), 1'b1);
    run_msg(make_hdr(4'd5, 4'd10, 5'b11011, 1'b1), 1'b1);
    run_msg(make_hdr(4'd7, 4'd3, 5'b11011, 1'b0), 1'b0);

    // Parity errors up to and past saturation, then clear-vs-increment.
    bad = make_hdr(4'd3, 4'd0, 5'd0, 1'b0) ^ 64'd1;
    run_msg(bad, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send_word(bad);
      bump_err();
    end
    check_eq("errcnt_sat", 64'(err_cnt), 64'(err_model));
    check_eq("errcnt_sat_abs", 64'(err_cnt), 64'(255));
    deser_data  = bad;
    de_ser_done = 1'b1;
    err_clr     = 1'b1;
    tick();
    de_ser_done = 1'b0;
    err_clr     = 1'b0;
    err_model   = 0;
    check_eq("clr_perr", 64'(pulses), 64'(P_PERR));
    check_eq("clr_wins", 64'(err_cnt), 64'(0));
    run_msg(bad, 1'b1);

    // Header never completes.
    send_word(make_hdr(4'd2, 4'd0, 5'd1, 1'b0));
    check_eq("tmo_hdr_en", 64'(pulses), 64'(P_HDR));
    n = 0;
    while (!timeout && n < 400) begin
      tick();
      n++;
    end
    check_eq("tmo_cycles", 64'(n), 64'(TIMEOUT_CYC));
    check_eq("tmo_pulse", 64'(pulses), 64'(P_TMO));
    run_msg(make_hdr(4'd9, 4'd10, 5'd2, 1'b1), 1'b1);

    // Completion on the last allowed cycle beats the timeout.
    send_word(make_hdr(4'd2, 4'd0, 5'd1, 1'b0));
    check_eq("race_hdr_en", 64'(pulses), 64'(P_HDR));
    repeat (TIMEOUT_CYC - 1) tick();
    header_valid = 1'b1;
    tick();
    header_valid = 1'b0;
    check_eq("race_msg", 64'(pulses), 64'(P_MSG));

    // LTSM drops to RESET during payload.
    send_word(make_hdr(4'd4, 4'd0, 5'b11011, 1'b0));
    check_eq("abort_hdr_en", 64'(pulses), 64'(P_HDR));
    header_valid = 1'b1;
    tick();
    header_valid = 1'b0;
    send_word({$urandom, $urandom});
    check_eq("abort_data0", 64'(pulses), 64'(P_DATA));
    check_eq("abort_idx0", 64'(data_idx), 64'(0));
    state_in = 3'd0;
    tick();
    check_eq("abort_quiet", 64'(pulses), 64'(0));
    state_in = 3'd3;
    send_word({$urandom, $urandom} & ~PAT);
    check_eq("abort_idle_word", 64'(pulses), 64'(0));
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check_eq("abort_no_msg", 64'(pulses), 64'(0));
    send_word(PAT);
    check_eq("relock_1", 64'(pulses), 64'(0));
    send_word(PAT);
    check_eq("relock_2", 64'(pulses), 64'(P_SAMP));

    // Asynchronous reset in the middle of the pattern phase.
    run_msg(bad, 1'b1);
    state_in = 3'd0;
    tick();
    check_eq("to_idle_quiet", 64'(pulses), 64'(0));
    send_word(PAT);
    check_eq("mid_start", 64'(pulses), 64'(P_START));
    #2;
    rst_n = 1'b0;
    #1;
    err_model = 0;
    check_eq("async_pulses", 64'(pulses), 64'(0));
    check_eq("async_errcnt", 64'(err_cnt), 64'(0));
    check_eq("async_idx", 64'(data_idx), 64'(0));
    #1;
    rst_n = 1'b1;
    tick();
    send_word(PAT);
    check_eq("post_rst_start", 64'(pulses), 64'(P_START));
    send_word(PAT);
    check_eq("post_rst_samp", 64'(pulses), 64'(P_SAMP));

    // Random traffic in DECODE.
    for (int k = 0; k < 80; k++) begin
      state_in = 3'($urandom_range(1, 7));
      case ($urandom_range(0, 5))
        0: w = PAT;
        1: begin
          w     = {$urandom, $urandom};
          w[56] = 1'b1;
        end
        2: begin
          n = $urandom_range(0, 62);
          if (n == 56) n = 0;
          w = make_hdr(4'($urandom_range(0, 15)), 4'($urandom), 5'($urandom), 1'($urandom));
          w[n] = ~w[n];
        end
        3: w = make_hdr(4'd0, 4'($urandom), 5'($urandom), 1'($urandom));
        4: begin
          w = make_hdr(4'($urandom_range(1, 15)),
                       ($urandom_range(0, 1) == 1) ? 4'd10 : 4'($urandom),
                       5'($urandom_range(0, 26)), 1'($urandom));
        end
        default: w = make_hdr(4'($urandom_range(1, 15)), 4'($urandom), 5'b11011, 1'($urandom));
      endcase
      run_msg(w, $urandom_range(0, 3) != 0);
      tick();
      check_eq("rand_idle", 64'(pulses), 64'(0));
    end
    check_eq("final_errcnt", 64'(err_cnt), 64'(err_model));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
